// File: rtl/jt900h_memwait.sv
// jt900h_memwait: wait-state bridge between the jt900h RAM port and a
// req/ack memory, with a one-word read cache and an access timeout.
module jt900h_memwait #(
    parameter int TOUT = 255
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen_in,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_din,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Timer value seen in the last BUSY cycle before giving up
    localparam logic [7:0] TLAST = 8'(TOUT - 1);

    state_t      state_q, state_d;
    logic [22:0] tag_q, tag_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  timer_q, timer_d;
    logic        err_q, err_d;
    logic        rdto_q, rdto_d;
    logic        cen_c;
    logic [15:0] din_c;
    logic        hit;

    assign hit = valid_q && (tag_q == cpu_addr[23:1]);

    // Next-state, cache update and CPU-side outputs
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        req_d   = req_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        timer_d = timer_q;
        err_d   = err_q;
        rdto_d  = rdto_q;
        cen_c   = 1'b0;
        din_c   = data_q;
        case (state_q)
            IDLE: begin
                if (cpu_we == 2'b00 && hit) begin
                    cen_c = cen_in;
                end else begin
                    addr_d  = cpu_addr[23:1];
                    we_d    = cpu_we;
                    wdata_d = cpu_dout;
                    req_d   = 1'b1;
                    timer_d = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                timer_d = timer_q + 8'd1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (we_q == 2'b00) begin
                        tag_d   = addr_q;
                        data_d  = mem_rdata;
                        valid_d = 1'b1;
                    end else if (tag_q == addr_q) begin
                        if (we_q[1]) data_d[15:8] = wdata_q[15:8];
                        if (we_q[0]) data_d[7:0]  = wdata_q[7:0];
                    end
                end else if (timer_q == TLAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (we_q == 2'b00) begin
                        valid_d = 1'b0;
                        rdto_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                cen_c = cen_in;
                if (rdto_q) din_c = 16'hFFFF;
                if (cen_in) begin
                    state_d = IDLE;
                    rdto_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            rdto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            rdto_q  <= rdto_d;
        end
    end

    assign cpu_cen   = cen_c & ~rst;
    assign cpu_din   = din_c;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jt900h_memwait.sv
// tb_jt900h_memwait: randomized accesses against a transaction-level model
// of the cache, the external memory and the CPU stall rules.
module tb_jt900h_memwait;

    localparam int TOUT = 8;

    logic        rst, clk, cen_in, cpu_cen;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_dout, cpu_din;
    logic [1:0]  cpu_we;
    logic        mem_req, mem_ack, err;
    logic [22:0] mem_addr;
    logic [1:0]  mem_we;
    logic [15:0] mem_wdata, mem_rdata;

    jt900h_memwait #(.TOUT(TOUT)) dut (
        .rst(rst), .clk(clk), .cen_in(cen_in), .cpu_cen(cpu_cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // External memory contents (environment state)
    logic [15:0] mem [logic [22:0]];

    function automatic logic [15:0] mem_get(input logic [22:0] w);
        if (mem.exists(w)) return mem[w];
        return {w[7:0], ~w[7:0]};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[1]) r[15:8] = nw[15:8];
        if (be[0]) r[7:0] = nw[7:0];
        return r;
    endfunction

    // Reference model of the one-word cache and the sticky error
    logic        m_valid = 1'b0;
    logic [22:0] m_tag = '0;
    logic [15:0] m_data = '0;
    logic        m_err = 1'b0;

    // Memory responder
    int  resp_lat = 0;
    bit  resp_noack = 0;
    bit  inj_ack = 0;
    int  rcnt = 0;
    bit  acked = 0;

    always @(posedge clk) begin
        #2;
        mem_ack = 1'b0;
        if (inj_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 16'hDEAD;
            inj_ack = 0;
        end else if (!mem_req) begin
            rcnt = 0;
            acked = 0;
        end else if (!resp_noack && !acked) begin
            rcnt++;
            if (rcnt == resp_lat + 1) begin
                mem_ack = 1'b1;
                acked = 1;
                if (mem_we == 2'b00) mem_rdata = mem_get(mem_addr);
                else mem[mem_addr] = merge(mem_get(mem_addr), mem_wdata, mem_we);
            end
        end
    end

    // Bus-side monitor: request stability and request counting
    logic [22:0] exp_maddr = '0;
    logic [1:0]  exp_mwe = '0;
    logic [15:0] exp_mwd = '0;
    logic        req_prev = 1'b0;
    int          rises = 0;
    int          req_hi = 0;
    logic [1:0]  last_mwe = '0;
    logic [15:0] last_mwd = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            req_hi++;
            last_mwe = mem_we;
            last_mwd = mem_wdata;
            if (!req_prev) rises++;
            check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
            check("mem_we", 32'(mem_we), 32'(exp_mwe));
            check("mem_wdata", 32'(mem_wdata), 32'(exp_mwd));
        end
        req_prev = mem_req;
    end

    // One CPU access; called at 1 time unit after a rising edge
    task automatic access(input logic [23:0] a, input logic [1:0] we,
                          input logic [15:0] wd, input int lat,
                          input bit noack, input int mode, input bit inj,
                          output int stall_o, output logic [15:0] din_o);
        logic [22:0] word;
        logic [15:0] exp_d;
        bit hit, done, cen, ec;
        int stall, r0;
        word  = a[23:1];
        hit   = (we == 2'b00) && m_valid && (m_tag == word);
        stall = hit ? 0 : (noack ? TOUT + 1 : lat + 2);
        exp_d = hit ? m_data : (noack ? 16'hFFFF : mem_get(word));
        cpu_addr = a;
        cpu_we = we;
        cpu_dout = wd;
        resp_lat = lat;
        resp_noack = noack;
        inj_ack = inj;
        exp_maddr = word;
        exp_mwe = we;
        exp_mwd = wd;
        r0 = rises;
        req_hi = 0;
        done = 0;
        stall_o = 0;
        din_o = '0;
        for (int c = 0; c < stall + 64 && !done; c++) begin
            if (mode == 0) cen = 1;
            else if (mode == 1) cen = (c % 2) == 1;
            else cen = ($urandom % 2) == 1;
            cen_in = cen;
            @(negedge clk);
            ec = (c >= stall) && cen;
            check("cpu_cen", 32'(cpu_cen), 32'(ec));
            if (!cpu_cen) stall_o++;
            if (ec) begin
                done = 1;
                din_o = cpu_din;
                if (we == 2'b00) check("cpu_din", 32'(cpu_din), 32'(exp_d));
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            $display("FAIL access_bound: addr %0h never completed", a);
        end
        check("req_count", 32'(rises - r0), hit ? 0 : 1);
        check("req_cycles", 32'(req_hi), hit ? 0 : (noack ? TOUT : lat + 1));
        if (!hit) begin
            if (we == 2'b00) begin
                if (noack) m_valid = 1'b0;
                else begin
                    m_valid = 1'b1;
                    m_tag = word;
                    m_data = exp_d;
                end
            end else if (!noack && m_tag == word) begin
                m_data = merge(m_data, wd, we);
            end
            if (noack) m_err = 1'b1;
        end
        check("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        logic [15:0] d;
        int r;
        logic [1:0] rwe;
        rst = 1'b1;
        cen_in = 1'b1;
        cpu_addr = '0;
        cpu_we = '0;
        cpu_dout = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mem[23'h000401] = 16'h01FE;

        @(negedge clk);
        @(negedge clk);
        check("rst_cpu_cen", 32'(cpu_cen), 0);
        check("rst_cpu_din", 32'(cpu_din), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        access(24'h000802, 2'b00, 16'h0, 3, 0, 0, 0, st, d);
        check("cold_stall", 32'(st), 5);
        check("cold_data", 32'(d), 32'h01FE);
        access(24'h000803, 2'b00, 16'h0, 3, 0, 0, 0, st, d);
        check("hit_stall", 32'(st), 0);
        check("hit_data", 32'(d), 32'h01FE);

        access(24'h000802, 2'b10, 16'hAB00, 2, 0, 0, 0, st, d);
        check("wr_mem_we", 32'(last_mwe), 32'h2);
        check("wr_mem_wdata", 32'(last_mwd), 32'hAB00);
        access(24'h000802, 2'b00, 16'h0, 0, 0, 0, 0, st, d);
        check("merge_stall", 32'(st), 0);
        check("merge_data", 32'(d), 32'hABFE);

        r = rises;
        access(24'h00FFFE, 2'b11, 16'h1234, 2, 0, 1, 0, st, d);
        check("wr_uncached_reqs", 32'(rises - r), 1);
        access(24'h000803, 2'b00, 16'h0, 0, 0, 0, 0, st, d);
        check("valid_kept_stall", 32'(st), 0);
        check("valid_kept_data", 32'(d), 32'hABFE);

        access(24'h000A00, 2'b00, 16'h0, 3, 0, 1, 0, st, d);
        access(24'h000A10, 2'b00, 16'h0, 4, 0, 1, 0, st, d);
        check("toggle_data", 32'(d), 32'h08F7);

        access(24'h123456, 2'b00, 16'h0, 0, 1, 0, 0, st, d);
        check("tout_data", 32'(d), 32'hFFFF);
        check("tout_err", 32'(err), 1);
        check("tout_stall", 32'(st), 9);
        r = rises;
        access(24'h123456, 2'b00, 16'h0, 1, 0, 0, 0, st, d);
        check("tout_rereq", 32'(rises - r), 1);
        check("tout_reread", 32'(d), 32'h2BD4);

        cpu_addr = 24'h000900;
        cpu_we = 2'b00;
        cpu_dout = 16'h0;
        cen_in = 1'b1;
        resp_noack = 1;
        exp_maddr = 23'h000480;
        exp_mwe = 2'b00;
        exp_mwd = 16'h0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        check("rst_busy_req", 32'(mem_req), 0);
        check("rst_busy_cen", 32'(cpu_cen), 0);
        m_valid = 1'b0;
        m_err = 1'b0;
        resp_noack = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(24'h000900, 2'b00, 16'h0, 2, 0, 0, 1, st, d);
        check("late_ack_stall", 32'(st), 4);
        check("late_ack_data", 32'(d), 32'h807F);

        for (int i = 0; i < 160; i++) begin
            logic [22:0] w;
            w = 23'h000400 + 23'($urandom % 6);
            rwe = ($urandom % 10 < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            access({w, 1'($urandom % 2)}, rwe, 16'($urandom),
                   int'($urandom % 6), ($urandom % 25) == 0,
                   int'($urandom % 3), 0, st, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
